multicycle_mips_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS datapath.
- One ALU and one unified instruction/data memory port are shared across cycles.
- A control FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- The memory port uses a req/ready handshake, so external memory may insert wait states.
- Sits at CPU top level; the testbench or SoC provides the memory model.

---
 rtl/multicycle_mips_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_mips_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_mips_core
// Purpose  : Multi-cycle MIPS subset core (add/sub/and/or/slt, addi, lw, sw,
//            beq, halt) with one shared ALU and one unified memory port using
//            a req/ready handshake. Define JUMP_EN to make opcode 0x02 (j)
//            legal; otherwise it halts the core like any illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_mips_core #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_EXEC_R   = 4'd2;
    localparam logic [3:0] c_ST_WB_R     = 4'd3;
    localparam logic [3:0] c_ST_EXEC_I   = 4'd4;
    localparam logic [3:0] c_ST_WB_I     = 4'd5;
    localparam logic [3:0] c_ST_EXEC_MEM = 4'd6;
    localparam logic [3:0] c_ST_MEM      = 4'd7;
    localparam logic [3:0] c_ST_WB_L     = 4'd8;
    localparam logic [3:0] c_ST_BRANCH   = 4'd9;
    localparam logic [3:0] c_ST_JUMP     = 4'd10;
    localparam logic [3:0] c_ST_HALT     = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
`ifdef JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'h02;
`endif
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [5:0]        c_NUM_REGS  = 6'(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_PC_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    // PC bits kept by a jump: everything above the 28-bit region
    localparam logic [ADDR_W-1:0] c_J_KEEP    = ~ADDR_W'(32'h0FFF_FFFF);

    logic [3:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic [31:0]       r_ir;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_alu_out;
    logic [31:0]       r_mdr;
    logic [31:0]       r_gpr [32];

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [5:0]        w_funct;
    logic [31:0]       w_imm_sext;
    logic signed [31:0] w_br_off32;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jump_target;
    logic [31:0]       w_rs_val;
    logic [31:0]       w_rt_val;
    logic [31:0]       w_alu_res;
    logic              w_funct_ok;
    logic              w_is_sw;
    logic              w_wr_en;
    logic [4:0]        w_wr_idx;
    logic [31:0]       w_wr_data;

    assign w_op          = r_ir[31:26];
    assign w_rs          = r_ir[25:21];
    assign w_rt          = r_ir[20:16];
    assign w_rd          = r_ir[15:11];
    assign w_funct       = r_ir[5:0];
    assign w_imm_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_br_off32    = $signed({w_imm_sext[29:0], 2'b00});
    assign w_br_off      = ADDR_W'(w_br_off32);
    assign w_jump_target = (r_pc & c_J_KEEP) | ADDR_W'({r_ir[25:0], 2'b00});
    assign w_is_sw       = (w_op == c_OP_SW);

    // Register file reads: $0 and unimplemented indices read as zero
    assign w_rs_val = (w_rs != 5'd0 && {1'b0, w_rs} < c_NUM_REGS) ? r_gpr[w_rs] : 32'd0;
    assign w_rt_val = (w_rt != 5'd0 && {1'b0, w_rt} < c_NUM_REGS) ? r_gpr[w_rt] : 32'd0;

    // R-type ALU operation on the latched operands
    always_comb begin
        w_alu_res  = 32'd0;
        w_funct_ok = 1'b1;
        case (w_funct)
            c_FN_ADD: w_alu_res = r_a + r_b;
            c_FN_SUB: w_alu_res = r_a - r_b;
            c_FN_AND: w_alu_res = r_a & r_b;
            c_FN_OR:  w_alu_res = r_a | r_b;
            c_FN_SLT: w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
            default:  w_funct_ok = 1'b0;
        endcase
    end

    // Write-back port selection: rd for R-type, rt for addi and lw
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_rt;
        w_wr_data = r_alu_out;
        case (r_state)
            c_ST_WB_R: begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_rd;
            end
            c_ST_WB_I: w_wr_en = 1'b1;
            c_ST_WB_L: begin
                w_wr_en   = 1'b1;
                w_wr_data = r_mdr;
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    // Register file storage; writes to $0 or beyond NUM_REGS are dropped
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
        end else if (w_wr_en && w_wr_idx != 5'd0 && {1'b0, w_wr_idx} < c_NUM_REGS) begin
            r_gpr[w_wr_idx] <= w_wr_data;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= c_ST_FETCH;
            r_pc      <= RESET_PC;
            r_target  <= '0;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_alu_out <= 32'd0;
            r_mdr     <= 32'd0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + c_PC_STEP;
                        r_state <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    r_target <= r_pc + w_br_off;
                    case (w_op)
                        c_OP_RTYPE:       r_state <= c_ST_EXEC_R;
                        c_OP_ADDI:        r_state <= c_ST_EXEC_I;
                        c_OP_LW, c_OP_SW: r_state <= c_ST_EXEC_MEM;
                        c_OP_BEQ:         r_state <= c_ST_BRANCH;
`ifdef JUMP_EN
                        c_OP_J:           r_state <= c_ST_JUMP;
`endif
                        default:          r_state <= c_ST_HALT;
                    endcase
                end
                c_ST_EXEC_R: begin
                    if (w_funct_ok) begin
                        r_alu_out <= w_alu_res;
                        r_state   <= c_ST_WB_R;
                    end else begin
                        r_state <= c_ST_HALT;
                    end
                end
                c_ST_EXEC_I: begin
                    r_alu_out <= r_a + w_imm_sext;
                    r_state   <= c_ST_WB_I;
                end
                c_ST_EXEC_MEM: begin
                    r_alu_out <= r_a + w_imm_sext;
                    r_state   <= c_ST_MEM;
                end
                c_ST_MEM: begin
                    if (mem_ready) begin
                        if (w_is_sw) begin
                            r_state <= c_ST_FETCH;
                        end else begin
                            r_mdr   <= mem_rdata;
                            r_state <= c_ST_WB_L;
                        end
                    end
                end
                c_ST_WB_R, c_ST_WB_I, c_ST_WB_L: r_state <= c_ST_FETCH;
                c_ST_BRANCH: begin
                    if (r_a == r_b) r_pc <= r_target;
                    r_state <= c_ST_FETCH;
                end
                c_ST_JUMP: begin
                    r_pc    <= w_jump_target;
                    r_state <= c_ST_FETCH;
                end
                c_ST_HALT: r_state <= c_ST_HALT;
                default:   r_state <= c_ST_HALT;
            endcase
        end
    end

    // Memory port and status; reset forces every output to its idle value
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        halted    = 1'b0;
        if (!Rst) begin
            case (r_state)
                c_ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = r_pc & c_WORD_MASK;
                end
                c_ST_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = w_is_sw;
                    mem_addr  = ADDR_W'(r_alu_out) & c_WORD_MASK;
                    mem_wdata = w_is_sw ? r_b : 32'd0;
                end
                c_ST_HALT: halted = 1'b1;
                default:   mem_req = 1'b0;
            endcase
        end
    end

    assign pc_out = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mips_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_mips_core
// Purpose  : Directed self-checking bench for multicycle_mips_core with a
//            unified word memory model that inserts a programmable number of
//            wait states on every access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_mips_core;

    logic        Clk;
    logic        Rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc_out;
    logic        halted;

    logic [31:0] mem [256];
    int          n_wait;
    int          wait_cnt;
    logic        mem_clr;
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [31:0] ld_data;
    int          wr_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int n_cmp;
    int n_mis;

    multicycle_mips_core #(
        .ADDR_W   (32),
        .RESET_PC (32'h40),
        .NUM_REGS (32)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc_out    (pc_out),
        .halted    (halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && (wait_cnt == n_wait);

    // Memory model: program loading, clearing and handshake writes
    always @(posedge Clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            wr_cnt  <= 0;
            wr_addr <= 32'd0;
            wr_data <= 32'd0;
        end else if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input int addr, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_idx  = 8'(addr >> 2);
        ld_data = d;
        tick(1);
        ld_en   = 1'b0;
    endtask

    // Hold reset, wipe memory and select the wait-state count for the next program
    task automatic setup(input int waits);
        Rst     = 1'b1;
        n_wait  = waits;
        mem_clr = 1'b1;
        tick(1);
        mem_clr = 1'b0;
    endtask

    task automatic release_rst();
        Rst = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        wait_cnt = 0;
        wr_cnt   = 0;
        wr_addr  = 32'd0;
        wr_data  = 32'd0;
        ld_en    = 1'b0;
        ld_idx   = 8'd0;
        ld_data  = 32'd0;
        mem_clr  = 1'b0;
        n_wait   = 0;
        Rst      = 1'b1;
        tick(1);

        // Program A: addi/addi/add/halt, zero wait states
        setup(0);
        put(32'h40, 32'h2001_0005);   // addi $1,$0,5
        put(32'h44, 32'h2002_0007);   // addi $2,$0,7
        put(32'h48, 32'h0022_1820);   // add  $3,$1,$2
        put(32'h4C, 32'hFC00_0000);   // halt
        tick(2);
        check("rst_pc",     pc_out,           32'h40);
        check("rst_req",    32'(mem_req),     32'd0);
        check("rst_we",     32'(mem_we),      32'd0);
        check("rst_addr",   mem_addr,         32'd0);
        check("rst_wdata",  mem_wdata,        32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        release_rst();
        check("first_req",  32'(mem_req),     32'd1);
        check("first_addr", mem_addr,         32'h40);
        check("first_we",   32'(mem_we),      32'd0);
        tick(13);
        check("a_halt_early", 32'(halted),    32'd0);
        tick(1);
        check("a_halted",   32'(halted),      32'd1);
        check("a_r3",       dut.r_gpr[3],     32'd12);
        check("a_pc",       pc_out,           32'h50);
        check("a_req_idle", 32'(mem_req),     32'd0);
        tick(3);
        check("a_pc_frozen", pc_out,          32'h50);
        check("a_halt_sticky", 32'(halted),   32'd1);

        // Program F: ALU functions, $0 protection, illegal funct
        setup(0);
        put(32'h40, 32'h2001_FFFD);   // addi $1,$0,-3
        put(32'h44, 32'h2002_0005);   // addi $2,$0,5
        put(32'h48, 32'h0022_1822);   // sub  $3,$1,$2
        put(32'h4C, 32'h0022_2024);   // and  $4,$1,$2
        put(32'h50, 32'h0022_2825);   // or   $5,$1,$2
        put(32'h54, 32'h0022_302A);   // slt  $6,$1,$2
        put(32'h58, 32'h0041_382A);   // slt  $7,$2,$1
        put(32'h5C, 32'h2000_0009);   // addi $0,$0,9
        put(32'h60, 32'h0001_4020);   // add  $8,$0,$1
        put(32'h64, 32'h0000_0000);   // funct 0x00 -> illegal
        release_rst();
        tick(38);
        check("f_halt_early", 32'(halted),    32'd0);
        tick(1);
        check("f_halted",   32'(halted),      32'd1);
        check("f_r1_addi_neg", dut.r_gpr[1],  32'hFFFF_FFFD);
        check("f_r2",       dut.r_gpr[2],     32'd5);
        check("f_sub",      dut.r_gpr[3],     32'hFFFF_FFF8);
        check("f_and",      dut.r_gpr[4],     32'd5);
        check("f_or",       dut.r_gpr[5],     32'hFFFF_FFFD);
        check("f_slt_true", dut.r_gpr[6],     32'd1);
        check("f_slt_false", dut.r_gpr[7],    32'd0);
        check("f_r0_read",  dut.r_gpr[8],     32'hFFFF_FFFD);
        check("f_pc",       pc_out,           32'h68);

        // Program B: sw/lw with 3 wait states, misaligned lw address
        setup(3);
        put(32'h40, 32'h2003_000C);   // addi $3,$0,12
        put(32'h44, 32'hAC03_0008);   // sw   $3,8($0)
        put(32'h48, 32'h8C04_0008);   // lw   $4,8($0)
        put(32'h4C, 32'h8C05_000B);   // lw   $5,11($0)
        put(32'h50, 32'hFC00_0000);   // halt
        release_rst();
        tick(14);
        check("b_sw_req",   32'(mem_req),     32'd1);
        check("b_sw_we",    32'(mem_we),      32'd1);
        check("b_sw_addr",  mem_addr,         32'h8);
        check("b_sw_wdata", mem_wdata,        32'd12);
        tick(1);
        check("b_sw_addr_hold",  mem_addr,    32'h8);
        check("b_sw_wdata_hold", mem_wdata,   32'd12);
        check("b_sw_nowrite_yet", 32'(wr_cnt), 32'd0);
        tick(2);
        check("b_wr_cnt",   32'(wr_cnt),      32'd1);
        check("b_wr_addr",  wr_addr,          32'h8);
        check("b_wr_data",  wr_data,          32'd12);
        tick(10);
        check("b_lw_before_wb", dut.r_gpr[4], 32'd0);
        tick(1);
        check("b_lw_r4",    dut.r_gpr[4],     32'd12);
        tick(7);
        check("b_lw_mis_addr", mem_addr,      32'h8);
        check("b_lw_we",    32'(mem_we),      32'd0);
        tick(4);
        check("b_lw_r5",    dut.r_gpr[5],     32'd12);
        tick(4);
        check("b_halt_early", 32'(halted),    32'd0);
        tick(1);
        check("b_halted",   32'(halted),      32'd1);
        check("b_mem_word", mem[2],           32'd12);

        // Program C: reset while sw waits in MEM
        setup(3);
        put(32'h40, 32'h2003_000C);
        put(32'h44, 32'hAC03_0008);
        put(32'h48, 32'hFC00_0000);
        release_rst();
        tick(15);
        check("c_in_mem_we", 32'(mem_we),     32'd1);
        Rst = 1'b1;
        tick(1);
        check("c_req_drop", 32'(mem_req),     32'd0);
        check("c_pc_reset", pc_out,           32'h40);
        check("c_no_write", 32'(wr_cnt),      32'd0);
        check("c_mem_kept", mem[2],           32'd0);
        check("c_r3_reset", dut.r_gpr[3],     32'd0);
        release_rst();
        check("c_refetch",  mem_addr,         32'h40);

        // Program D: beq not taken then taken self-loop
        setup(0);
        put(32'h40, 32'h2001_0005);   // addi $1,$0,5
        put(32'h44, 32'h2002_0007);   // addi $2,$0,7
        put(32'h48, 32'h1022_0005);   // beq  $1,$2,+5 (not taken)
        put(32'h4C, 32'h1021_FFFF);   // beq  $1,$1,-1 (self loop)
        release_rst();
        tick(11);
        check("d_nt_pc",    pc_out,           32'h4C);
        check("d_nt_addr",  mem_addr,         32'h4C);
        tick(2);
        check("d_t_fetched", pc_out,          32'h50);
        tick(1);
        check("d_t_pc",     pc_out,           32'h4C);
        check("d_t_addr",   mem_addr,         32'h4C);
        tick(2);
        check("d_t_pc2a",   pc_out,           32'h50);
        tick(1);
        check("d_t_pc2",    pc_out,           32'h4C);
        check("d_no_halt",  32'(halted),      32'd0);

        // Program E: j 0x10
        setup(0);
        put(32'h40, 32'h0800_0010);   // j 0x10 -> 0x40
        release_rst();
        tick(2);
        check("e_fetched",  pc_out,           32'h44);
        tick(1);
`ifdef JUMP_EN
        check("e_jump_pc",  pc_out,           32'h40);
        check("e_jump_nohalt", 32'(halted),   32'd0);
        tick(3);
        check("e_jump_pc2", pc_out,           32'h40);
`else
        check("e_illegal_halt", 32'(halted),  32'd1);
        check("e_illegal_pc", pc_out,         32'h44);
        tick(3);
        check("e_illegal_req", 32'(mem_req),  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
